// File: rtl/fft_sample_feeder_pkg.sv
// Shared constants for the FFT input path: FIFO data width, frame length tied to
// the cache address range, and the frame FSM state encoding.
package fft_sample_feeder_pkg;

    localparam int FIFO_DATA_W    = 17;
    localparam int CACHE_ADDR_MAX = 255;
    localparam int FFT_FRAME_LEN  = CACHE_ADDR_MAX + 1;
    localparam int FIFO_DEPTH     = 512;
    localparam int FIFO_AFULL_LVL = 448;

    // Reset values of the cache-facing status flags.
    localparam logic RST_EMPTY   = 1'b1;
    localparam logic RST_LOCKED  = 1'b0;
    localparam logic RST_OVF     = 1'b0;

    typedef enum logic {
        FRAME_OPEN   = 1'b0,
        FRAME_LOCKED = 1'b1
    } frame_state_e;

endpackage

// File: rtl/fft_sync_fifo_ram.sv
// Simple dual-port sample store with a registered, enable-gated read port that
// holds its last value between reads.
module fft_sync_fifo_ram #(
    parameter int DATA_W = 17,
    parameter int DEPTH  = 512
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_sample_feeder.sv
// Front-end sample FIFO feeding the FFT cache: exactly FRAME_LEN pops per frame,
// then reports empty until the cache releases the frame.
module fft_sample_feeder
    import fft_sample_feeder_pkg::*;
#(
    parameter int DATA_W    = FIFO_DATA_W,
    parameter int DEPTH     = FIFO_DEPTH,
    parameter int FRAME_LEN = FFT_FRAME_LEN,
    parameter int AFULL_LVL = FIFO_AFULL_LVL
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    input  logic [DATA_W-1:0]        s_data,
    output logic                     s_ready,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        dout,
    output logic                     empty,
    input  logic                     frame_rel,
    input  logic                     clr_ovf,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     afull,
    output logic                     overflow,
    output logic                     frame_locked
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(FRAME_LEN);

    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_AFULL = LVL_W'(AFULL_LVL);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_LEN - 1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_next;
    logic [CNT_W-1:0] pop_cnt;
    frame_state_e     state;
    logic             push;
    logic             pop;

    // Status comes only from registered state, so a fresh write is never
    // visible to the cache in the same cycle.
    assign s_ready = (level != LVL_FULL);
    assign empty   = (level == '0) || frame_locked;
    assign push    = s_valid && s_ready;
    assign pop     = rd_en && !empty;

    always_comb begin
        level_next = level;
        if (push && !pop) begin
            level_next = level + LVL_W'(1);
        end else if (pop && !push) begin
            level_next = level - LVL_W'(1);
        end
    end

    fft_sync_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (s_data),
        .rd_en   (pop),
        .rd_addr (rd_ptr),
        .rd_data (dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            afull    <= 1'b0;
            overflow <= RST_OVF;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level <= level_next;
            afull <= (level_next >= LVL_AFULL);
            // A drop in the same cycle as a clear must stay visible.
            if (s_valid && !s_ready) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= FRAME_OPEN;
            pop_cnt      <= '0;
            frame_locked <= RST_LOCKED;
        end else begin
            case (state)
                FRAME_OPEN: begin
                    // Release aborts a partial frame and overrides a closing pop.
                    if (frame_rel) begin
                        pop_cnt <= '0;
                    end else if (pop) begin
                        if (pop_cnt == CNT_LAST) begin
                            state        <= FRAME_LOCKED;
                            pop_cnt      <= '0;
                            frame_locked <= 1'b1;
                        end else begin
                            pop_cnt <= pop_cnt + CNT_W'(1);
                        end
                    end
                end
                FRAME_LOCKED: begin
                    if (frame_rel) begin
                        state        <= FRAME_OPEN;
                        frame_locked <= 1'b0;
                    end
                end
                default: begin
                    state        <= FRAME_OPEN;
                    pop_cnt      <= '0;
                    frame_locked <= RST_LOCKED;
                end
            endcase
        end
    end

endmodule

// File: doc/fft_sample_feeder.md
Name: fft_sample_feeder

Overview:
- Input-side sample buffer that produces the 17-bit samples consumed by the FFT cache during its fill phase.
- Accepts samples from the acquisition front end over a valid/ready interface and stores them in a synchronous FIFO.
- Presents them to the cache using the cache's load protocol: empty flag drives the cache's ld_n; the cache's full_n drives rd_en; data is returned one cycle after a pop.
- Enforces frame boundaries: exactly FRAME_LEN pops per frame, then holds empty until the cache signals completion of the current transform.

Parameters:
DATA_W, 17, sample width (matches the shared FIFO data width)
DEPTH, 512, FIFO entries; power of two, >= FRAME_LEN
FRAME_LEN, 256, pops per frame (FFT points)
AFULL_LVL, 448, occupancy at or above which afull asserts

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  front-end sample valid
s_data  in  DATA_W  front-end sample
s_ready  out  1  FIFO can accept (not full)
rd_en  in  1  pop request (cache full_n)
dout  out  DATA_W  popped sample, registered
empty  out  1  no poppable data (to cache ld_n)
frame_rel  in  1  single-cycle pulse; releases frame lock (cache invbit_done)
clr_ovf  in  1  clears overflow
level  out  $clog2(DEPTH)+1  current occupancy
afull  out  1  level >= AFULL_LVL
overflow  out  1  sticky: s_valid seen while s_ready low
frame_locked  out  1  FRAME_LEN pops done, awaiting frame_rel

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. All pointers, level, and pop_cnt clear to 0. dout=0, empty=1, s_ready=1, afull=0, overflow=0, frame_locked=0.
- Push: occurs when s_valid && s_ready. s_ready = (level != DEPTH), combinational from registered level. Data written at wr_ptr; wr_ptr wraps modulo DEPTH.
- Pop: pop = rd_en && !empty.
  - Next cycle: dout <= mem[rd_ptr]; rd_ptr advances, wrapping modulo DEPTH.
  - dout holds its value when there is no pop.
  - Read latency is exactly 1 cycle from pop.
- empty = (level == 0) || frame_locked. Derived from registered state only. A word written in cycle N is poppable no earlier than cycle N+1; there is no fall-through.
- level: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - Simultaneous push and pop at level==DEPTH cannot occur (s_ready=0).
  - At level==0 no pop occurs.
- Frame FSM, states OPEN and LOCKED:
  - OPEN: pop_cnt increments on each pop. A pop when pop_cnt==FRAME_LEN-1 moves to LOCKED, clears pop_cnt, and sets frame_locked=1 on the following cycle.
  - LOCKED: pops are blocked (empty=1); pushes continue.
  - frame_rel in LOCKED: return to OPEN next cycle.
  - frame_rel in OPEN: clear pop_cnt (abort partial frame); the FIFO contents are not flushed.
  - frame_rel in the same cycle as the FRAME_LEN-th pop: frame_rel wins; state is OPEN with pop_cnt=0.
- overflow: set when s_valid && !s_ready. Cleared by clr_ovf. If both occur in the same cycle, set wins. Dropped samples are not stored.
- afull: registered comparison of the next level against AFULL_LVL.
- Reset asserted mid-frame: all state is discarded immediately. No partial frame is preserved.

Decomposition:
- Shared include carries the FIFO data width, FRAME_LEN (cache address max + 1), and the reset constants. The existing width define is reused for DATA_W.
- One natural sub-module: fft_sync_fifo_ram, a simple dual-port DEPTH x DATA_W array with registered read.
- Pointer, level, and frame FSM logic stay in the top module.

Test Plan:
- Reset with s_valid=1 during reset -> after release: empty=1, s_ready=1, level=0, dout=0, overflow=0.
- Push 0x00001..0x00100 (256 words) with rd_en=0, then hold rd_en=1 -> dout shows 0x00001..0x00100 in order, each 1 cycle after its pop. Then frame_locked=1 and empty=1, with level=0 and no further pops.
- Push 300 words, pop continuously -> exactly 256 pops, then empty=1 while level=44. Pulse frame_rel -> empty=0 next cycle; next dout=word 257.
- Fill to 512 with s_valid held high -> s_ready=0 at level=512, afull=1 from level 448, overflow=1 on the 513th valid. clr_ovf -> overflow=0.
- Simultaneous push and pop at level=10 for 20 cycles -> level stays 10; output order preserved across wr_ptr/rd_ptr wraparound at 511->0.
- frame_rel pulsed in the same cycle as the 256th pop -> frame_locked stays 0, pop_cnt=0. Assert rst_n low mid-frame -> all outputs return to reset values asynchronously.
